// File: rtl/byte_decode_stream.sv
// rtl/byte_decode_stream.sv - streaming ByteDecode_d: packed words in, one D-bit coefficient per handshake out
module byte_decode_stream #(
  parameter int IN_W  = 32,
  parameter int D     = 12,
  parameter int K     = 3,
  parameter int N     = 256,
  parameter int Q     = 3329,
  parameter int OUT_W = 12,
  localparam int PW   = (K > 1) ? $clog2(K) : 1,
  localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] coeff,
  output logic             coeff_valid,
  input  logic             coeff_ready,
  output logic [PW-1:0]    poly_idx,
  output logic [CW-1:0]    coeff_idx,
  output logic             coeff_last,
  output logic             range_err,
  output logic             busy,
  output logic             done
);

  localparam int TOTAL_BITS = K * N * D;
  localparam int WORDS      = (TOTAL_BITS + IN_W - 1) / IN_W;
  localparam int BUF_W      = IN_W + D - 1;
  localparam int CNT_W      = $clog2(BUF_W + 1);
  localparam int WDW        = $clog2(WORDS + 1);
  localparam int LDW        = $clog2(K * N + 1);

  localparam logic [CNT_W-1:0] D_C     = CNT_W'(D);
  localparam logic [CNT_W-1:0] IN_C    = CNT_W'(IN_W);
  localparam logic [WDW-1:0]   WORDS_C = WDW'(WORDS);
  localparam logic [LDW-1:0]   TOT_C   = LDW'(K * N);
  localparam logic [PW-1:0]    LAST_P  = PW'(K - 1);
  localparam logic [CW-1:0]    LAST_C  = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [BUF_W-1:0] buffer, buf_next, ext_in;
  logic [CNT_W-1:0] bit_cnt, cnt_next, cnt_shift;
  logic [WDW-1:0]   words_taken;
  logic [LDW-1:0]   loads;
  logic             out_full;
  logic             accept, load, hs, finish;
  logic [D-1:0]     raw;
  logic [31:0]      raw32;
  logic             raw_bad;
  logic [OUT_W-1:0] val;

  assign busy        = (state == S_RUN);
  assign done        = (state == S_DONE);
  assign in_ready    = busy && (bit_cnt < D_C) && (words_taken < WORDS_C);
  assign coeff_valid = out_full;
  assign coeff_last  = out_full && (poly_idx == LAST_P) && (coeff_idx == LAST_C);

  assign accept = in_valid && in_ready;
  assign hs     = out_full && coeff_ready;
  assign finish = hs && coeff_last;
  // Loads stop once K*N coefficients are out, so surplus tail bits never reach the output.
  assign load   = busy && (bit_cnt >= D_C) && (loads < TOT_C) && (!out_full || coeff_ready);

  // Raw coefficient from the buffer bottom, with conditional mod-q subtraction for 12-bit decode.
  always_comb begin
    raw     = buffer[D-1:0];
    raw32   = 32'(raw);
    raw_bad = (D == 12) && (raw32 >= 32'(Q));
    val     = OUT_W'(raw_bad ? (raw32 - 32'(Q)) : raw32);
  end

  // Gearbox: drop the consumed coefficient first, then append the new word above the remaining bits.
  always_comb begin
    ext_in              = '0;
    ext_in[IN_W-1:0]    = in_data;
    buf_next            = load ? (buffer >> D) : buffer;
    cnt_shift           = load ? (bit_cnt - D_C) : bit_cnt;
    cnt_next            = cnt_shift;
    if (accept) begin
      buf_next = buf_next | (ext_in << cnt_shift);
      cnt_next = cnt_shift + IN_C;
    end
  end

  // Run control, bit buffer, output register and index counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      buffer      <= '0;
      bit_cnt     <= '0;
      words_taken <= '0;
      loads       <= '0;
      out_full    <= 1'b0;
      coeff       <= '0;
      poly_idx    <= '0;
      coeff_idx   <= '0;
      range_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            range_err   <= 1'b0;
            buffer      <= '0;
            bit_cnt     <= '0;
            words_taken <= '0;
            loads       <= '0;
            out_full    <= 1'b0;
            poly_idx    <= '0;
            coeff_idx   <= '0;
          end
        end
        S_RUN: begin
          buffer  <= buf_next;
          bit_cnt <= cnt_next;
          if (accept) words_taken <= words_taken + WDW'(1);
          if (load) begin
            coeff    <= val;
            loads    <= loads + LDW'(1);
            out_full <= 1'b1;
            if (raw_bad) range_err <= 1'b1;
          end else if (hs) begin
            out_full <= 1'b0;
          end
          if (hs) begin
            if (coeff_idx == LAST_C) begin
              coeff_idx <= '0;
              poly_idx  <= coeff_last ? '0 : poly_idx + PW'(1);
            end else begin
              coeff_idx <= coeff_idx + CW'(1);
            end
          end
          if (finish) begin
            state    <= S_DONE;
            buffer   <= '0;
            bit_cnt  <= '0;
            out_full <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_decode_stream.sv
// tb/tb_byte_decode_stream.sv - directed and random checks of byte_decode_stream against a bit-level reference model
module tb_byte_decode_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, coeff_ready;
  logic [31:0] in_data;
  logic        in_ready, coeff_valid, coeff_last, range_err, busy, done;
  logic [11:0] coeff;
  logic [1:0]  poly_idx;
  logic [7:0]  coeff_idx;

  logic        start_b, in_valid_b, coeff_ready_b;
  logic [31:0] in_data_b;
  logic        in_ready_b, coeff_valid_b, coeff_last_b, range_err_b, busy_b, done_b;
  logic [11:0] coeff_b;
  logic [0:0]  poly_idx_b;
  logic [7:0]  coeff_idx_b;

  byte_decode_stream dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .coeff(coeff), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .poly_idx(poly_idx), .coeff_idx(coeff_idx), .coeff_last(coeff_last),
    .range_err(range_err), .busy(busy), .done(done)
  );

  byte_decode_stream #(.IN_W(32), .D(1), .K(1), .N(256)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .coeff(coeff_b), .coeff_valid(coeff_valid_b), .coeff_ready(coeff_ready_b),
    .poly_idx(poly_idx_b), .coeff_idx(coeff_idx_b), .coeff_last(coeff_last_b),
    .range_err(range_err_b), .busy(busy_b), .done(done_b)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] wa [288];
  int got [768];
  int beats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Coefficient j is bits j*12 .. j*12+11 of the concatenated LSB-first word stream, reduced mod 3329.
  function automatic int model_raw(int j);
    int raw;
    int p;
    logic [31:0] w;
    raw = 0;
    for (int b = 0; b < 12; b++) begin
      p = j * 12 + b;
      w = wa[p / 32];
      raw = raw | (int'(w[p % 32]) << b);
    end
    return raw;
  endfunction

  function automatic int model_coeff(int j);
    int r;
    r = model_raw(j);
    return (r >= 3329) ? r - 3329 : r;
  endfunction

  function automatic logic model_rerr();
    for (int j = 0; j < 768; j++) if (model_raw(j) >= 3329) return 1'b1;
    return 1'b0;
  endfunction

  // mode 0: free flowing, 1: random valid/ready, 2: 5-cycle stall at coefficient 10
  task automatic run_a(input int mode, input int abort_at, output int nbeats);
    int wi, k, cyc, stall;
    logic [31:0] hc, hp, hi;
    logic exp_rerr;
    exp_rerr = model_rerr();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    #1;
    chk("busy_after_start", busy, 1);
    chk("rerr_cleared_at_start", range_err, 0);
    wi = 0; k = 0; cyc = 0; stall = 0;
    hc = 0; hp = 0; hi = 0;
    while (k < 768 && cyc < 6000 && !(abort_at > 0 && k >= abort_at)) begin
      @(negedge clk);
      cyc++;
      in_valid = (wi < 288) && (mode != 1 || $urandom_range(3) != 0);
      in_data  = (wi < 288) ? wa[wi] : 32'h0;
      if (mode == 2 && k == 10 && stall < 5) coeff_ready = 1'b0;
      else if (mode == 1) coeff_ready = 1'($urandom_range(1));
      else coeff_ready = 1'b1;
      #1;
      if (mode == 2 && k == 10 && stall < 5 && coeff_valid) begin
        if (stall == 0) begin
          hc = 32'(coeff); hp = 32'(poly_idx); hi = 32'(coeff_idx);
        end else begin
          chk("stall_coeff", coeff, hc);
          chk("stall_poly", poly_idx, hp);
          chk("stall_cidx", coeff_idx, hi);
        end
        stall++;
        if (stall == 5) chk("stall_in_ready_low", in_ready, 0);
      end
      if (in_valid && in_ready) wi++;
      if (coeff_valid && coeff_ready) begin
        got[k] = int'(coeff);
        chk("coeff", coeff, model_coeff(k));
        chk("poly_idx", poly_idx, k / 256);
        chk("coeff_idx", coeff_idx, k % 256);
        chk("coeff_last", coeff_last, (k == 767) ? 1 : 0);
        k++;
      end
    end
    nbeats = k;
    if (abort_at == 0) begin
      chk("beat_count", k, 768);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("done_pulse", done, 1);
      chk("busy_in_done", busy, 0);
      chk("rerr_at_done", range_err, exp_rerr);
      @(negedge clk);
      #1;
      chk("done_one_cycle", done, 0);
      chk("rerr_held_idle", range_err, exp_rerr);
    end
  endtask

  initial begin
    int kb, cyc;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; coeff_ready = 1'b0; in_data = 32'h0;
    start_b = 1'b0; in_valid_b = 1'b0; coeff_ready_b = 1'b0; in_data_b = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_coeff_valid", coeff_valid, 0);
    chk("rst_coeff", coeff, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_coeff_last", coeff_last, 0);
    rst = 1'b0;

    // all-zero stream
    for (int i = 0; i < 288; i++) wa[i] = 32'h0;
    run_a(0, 0, beats);

    // known packing
    wa[0] = 32'h4567_8ABC;
    wa[1] = 32'h0000_0003;
    run_a(0, 0, beats);
    chk("known_c0", got[0], 2748);
    chk("known_c1", got[1], 1656);
    chk("known_c2", got[2], 837);

    // out-of-range raw values
    wa[0] = 32'h00FF_FFFF;
    wa[1] = 32'h0;
    run_a(0, 0, beats);
    chk("ff_c0", got[0], 766);
    chk("ff_c1", got[1], 766);
    chk("ff_rerr", range_err, 1);

    // backpressure on random data (start must clear range_err)
    for (int i = 0; i < 288; i++) wa[i] = 32'h0;
    wa[5] = $urandom() & 32'h0FFF_F000;
    run_a(2, 0, beats);

    // fully random data and handshakes
    for (int i = 0; i < 288; i++) wa[i] = $urandom();
    run_a(1, 0, beats);

    // abort mid-run, then a clean decode
    run_a(0, 100, beats);
    chk("abort_beats", beats, 100);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_coeff_valid", coeff_valid, 0);
    chk("abort_coeff", coeff, 0);
    chk("abort_poly", poly_idx, 0);
    chk("abort_cidx", coeff_idx, 0);
    chk("abort_last", coeff_last, 0);
    chk("abort_rerr", range_err, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_no_done", done, 0);
    run_a(0, 0, beats);

    // D=1, K=1 instance: alternating bits
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    in_valid_b = 1'b1; in_data_b = 32'hAAAA_AAAA; coeff_ready_b = 1'b1;
    kb = 0; cyc = 0;
    while (kb < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      #1;
      if (coeff_valid_b) begin
        chk("b_coeff", coeff_b, kb % 2);
        chk("b_cidx", coeff_idx_b, kb);
        chk("b_last", coeff_last_b, (kb == 255) ? 1 : 0);
        chk("b_done_early", done_b, 0);
        kb++;
      end
    end
    chk("b_beat_count", kb, 256);
    @(negedge clk);
    #1;
    chk("b_done", done_b, 1);
    chk("b_rerr", range_err_b, 0);
    chk("b_poly", poly_idx_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_decode_stream.md
Name: byte_decode_stream

Overview:
- Streaming, parametrised ByteDecode_d unit (FIPS 203) that replaces the flat combinational secret-key split.
- Packed key or ciphertext words enter through a valid/ready port. Each word is unpacked LSB-first through a gearbox bit buffer into D-bit coefficients for K polynomials of N coefficients each.
- Output is one coefficient per handshake, tagged with its polynomial and coefficient index.
- Sits between the key/ciphertext memory interface and the NTT/polynomial-arithmetic datapath. It serves sk/ek decode (D=12, mod-q check) and message/compressed decode (D<12).

Parameters:
- IN_W, 32, input word width in bits; must be ≥ D.
- D, 12, bits per packed coefficient, 1..12.
- K, 3, number of polynomials per decode run.
- N, 256, coefficients per polynomial.
- Q, 3329, modulus; used only when D==12.
- OUT_W, 12, output coefficient width (`KYBER_R_WIDTH`); must be ≥ D.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a decode run when idle
- in_data  in  IN_W  packed input word; bit 0 is the first bit of the stream
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- coeff  out  OUT_W  decoded coefficient, zero-extended
- coeff_valid  out  1  coeff and tags valid
- coeff_ready  in  1  downstream accepts coeff
- poly_idx  out  $clog2(K) (min 1)  polynomial index of coeff
- coeff_idx  out  $clog2(N)  coefficient index within the polynomial
- coeff_last  out  1  high with the final coefficient of the run (poly K-1, index N-1)
- range_err  out  1  sticky; a D==12 raw value ≥ Q was seen this run
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (async, rst=1): state=IDLE; buffer, bit count and all counters cleared. All outputs read 0: in_ready, coeff_valid, coeff, poly_idx, coeff_idx, coeff_last, range_err, busy, done.
- Constants:
  - TOTAL_BITS = K*N*D.
  - WORDS = ceil(TOTAL_BITS/IN_W).
  - BUF_W = IN_W + D − 1.
- State IDLE:
  - start=1 moves to RUN next cycle.
  - Entering RUN clears range_err, the buffer, the bit count, the word counter and both index counters.
- State RUN:
  - busy=1.
  - in_ready = (bit_cnt < D) && (words_taken < WORDS).
  - On an input handshake, in_data is placed at buffer[bit_cnt +: IN_W], bit_cnt += IN_W and words_taken++.
- Output register:
  - coeff_valid asserts when bit_cnt ≥ D and the output register is empty, or is being emptied that cycle.
  - Loading the register takes buffer[D−1:0], shifts the buffer right by D and sets bit_cnt −= D.
  - Input accept and output load may occur in the same cycle: bit_cnt_next = bit_cnt + IN_W − D.
- Latency: first coeff_valid appears 1 cycle after the first word that completes ≥ D bits. Sustained rate is 1 coeff/cycle while input keeps up.
- Backpressure: while coeff_valid && !coeff_ready, coeff, poly_idx, coeff_idx and coeff_last hold stable and no new load occurs.
- Arithmetic:
  - D==12: raw r in 0..4095. coeff = r ≥ Q ? r − Q : r. range_err is set (sticky) when r ≥ Q.
  - D<12: coeff = r zero-extended; range_err never sets.
- Index counters advance on each output handshake. coeff_idx wraps N−1→0 and increments poly_idx. coeff_last = (poly_idx==K−1 && coeff_idx==N−1).
- End of run:
  - The handshake of the coeff_last beat moves the block to DONE.
  - Surplus bits from the final word (TOTAL_BITS not a multiple of IN_W) are discarded, and the buffer is cleared.
- State DONE: done=1 and busy=0 for exactly one cycle, then IDLE. range_err holds its value until the next start.
- start during RUN or DONE is ignored.
- in_valid with in_ready=0 is not consumed; the source holds the word.
- rst asserted mid-run aborts immediately to the reset values; partial data is lost and no done pulse is produced.

Test Plan:
- Defaults, 288 words of 0 → 768 coeffs all 0; indices run (0,0)..(2,255); coeff_last only on the 768th; done pulses once; range_err=0.
- Defaults, word0=32'h4567_8ABC, word1=32'h0000_0003 → coeff[0]=0xABC (2748), coeff[1]=0x678 (1656), coeff[2]=0x345 (837).
- Defaults, word0=32'h00FF_FFFF → first two coeffs 4095 reduced to 766; range_err=1 and remains 1 through done; a new start clears it.
- Backpressure: hold coeff_ready=0 for 5 cycles at coeff 10 → coeff, poly_idx, coeff_idx stable; in_ready drops once bit_cnt ≥ D; no coefficient lost or duplicated across all 768.
- D=1, K=1, IN_W=32 instance: 8 words of 32'hAAAA_AAAA → 256 coeffs alternating 0,1; done after the 256th handshake.
- rst pulsed after 100 output beats → all outputs 0 immediately. A following start plus full stream decodes correctly from coefficient (0,0).
